// File: rtl/ysyx_220066_fetch_ctrl.sv
// ysyx_220066 fetch sequencer: owns the fetch PC, issues one imem request
// at a time and hands {pc, inst, err} to decode; redirects cancel stale work.
module ysyx_220066_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        fire;

  // Request and decode handshakes; redirect kills the decode offer
  always_comb begin
    imem_req_valid = ~rst & (state == REQ);
    imem_req_addr  = pc;
    out_valid      = ~rst & (state == HOLD) & ~redirect_valid;
    out_pc         = pc;
    fire           = out_valid & out_ready;
  end

  // Fetch FSM, PC, captured instruction and delivered-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      out_inst  <= 32'd0;
      out_err   <= 1'b0;
      fetch_cnt <= 64'd0;
    end else begin
      unique case (state)
        REQ: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= imem_req_ready ? DROP : REQ;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= imem_resp_valid ? REQ : DROP;
          end else if (imem_resp_valid) begin
            out_inst <= imem_resp_data;
            out_err  <= imem_resp_err;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= REQ;
          end else if (fire) begin
            pc        <= pc + 64'd4;
            fetch_cnt <= fetch_cnt + 64'd1;
            state     <= REQ;
          end
        end
        DROP: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (imem_resp_valid) begin
            state <= REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_fetch_ctrl.sv
// Directed bench for ysyx_220066_fetch_ctrl with request and output
// scoreboards; expected values come from the bench's own stimulus plan.
module tb_ysyx_220066_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;
  logic [63:0] fetch_cnt;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } out_t;

  out_t        exp_out[$];
  logic [63:0] exp_req[$];
  int          n_chk;
  int          n_pass;

  ysyx_220066_fetch_ctrl #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_err(out_err),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // settle inputs, then score any request accept / decode transfer
  task automatic probe();
    out_t        o;
    logic [63:0] a;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_expected", 64'(exp_req.size() != 0), 64'd1);
      if (exp_req.size() != 0) begin
        a = exp_req.pop_front();
        chk("req_addr", imem_req_addr, a);
      end
    end
    if (out_valid && out_ready) begin
      chk("out_expected", 64'(exp_out.size() != 0), 64'd1);
      if (exp_out.size() != 0) begin
        o = exp_out.pop_front();
        chk("out_pc", out_pc, o.pc);
        chk("out_inst", 64'(out_inst), 64'(o.inst));
        chk("out_err", 64'(out_err), 64'(o.err));
      end
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [63:0] addr);
    exp_req.push_back(addr);
    imem_req_ready = 1'b1;
    probe();
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_outv", 64'(out_valid), 64'd0);
    edge_();
    imem_req_ready = 1'b0;
  endtask

  task automatic resp(input logic [63:0] pc, input logic [31:0] inst,
                      input logic err, input logic deliver);
    imem_resp_valid = 1'b1;
    imem_resp_data  = inst;
    imem_resp_err   = err;
    if (deliver) exp_out.push_back('{pc: pc, inst: inst, err: err});
    probe();
    chk("resp_outv", 64'(out_valid), 64'd0);
    edge_();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    probe();
    chk("take_outv", 64'(out_valid), 64'd1);
    edge_();
  endtask

  task automatic fetch(input logic [63:0] addr, input logic [31:0] inst,
                       input logic err);
    req(addr);
    resp(addr, inst, err, 1'b1);
    take();
  endtask

  initial begin
    n_chk           = 0;
    n_pass          = 0;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    imem_resp_err   = 1'b0;
    out_ready       = 1'b1;
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    edge_();
    edge_();
    rst = 1'b0;
    probe();
    chk("reset_req_valid", 64'(imem_req_valid), 64'd1);
    chk("reset_addr", imem_req_addr, 64'h8000_0000);
    chk("reset_cnt", fetch_cnt, 64'd0);
    chk("reset_inst", 64'(out_inst), 64'd0);
    chk("reset_err", 64'(out_err), 64'd0);
    edge_();

    // straight-line fetch, 3 cycles per instruction
    fetch(64'h8000_0000, 32'h0000_0013, 1'b0);
    fetch(64'h8000_0004, 32'h0010_0093, 1'b0);
    fetch(64'h8000_0008, 32'h0020_0113, 1'b0);
    chk("straight_cnt", fetch_cnt, 64'd3);

    // decode stall
    req(64'h8000_000C);
    resp(64'h8000_000C, 32'h1111_1111, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      probe();
      chk("stall_outv", 64'(out_valid), 64'd1);
      chk("stall_pc", out_pc, 64'h8000_000C);
      chk("stall_inst", 64'(out_inst), 64'h1111_1111);
      chk("stall_no_req", 64'(imem_req_valid), 64'd0);
      chk("stall_cnt", fetch_cnt, 64'd3);
      edge_();
    end
    take();
    fetch(64'h8000_0010, 32'h2222_2222, 1'b0);

    // redirect during WAIT, late response dropped
    req(64'h8000_0014);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    probe();
    edge_();
    redirect_valid = 1'b0;
    probe();
    chk("drop_no_req", 64'(imem_req_valid), 64'd0);
    edge_();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    probe();
    chk("drop_no_req2", 64'(imem_req_valid), 64'd0);
    edge_();
    imem_resp_valid = 1'b0;
    fetch(64'h8000_1000, 32'h3333_3333, 1'b0);

    // redirect in HOLD with out_ready=1
    req(64'h8000_1004);
    resp(64'h8000_1004, 32'h4444_4444, 1'b0, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    out_ready      = 1'b1;
    probe();
    chk("hold_kill_outv", 64'(out_valid), 64'd0);
    edge_();
    redirect_valid = 1'b0;
    chk("hold_kill_cnt", fetch_cnt, 64'd6);
    fetch(64'h8000_2000, 32'h5555_5555, 1'b0);

    // redirect coinciding with response
    req(64'h8000_2004);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_3000;
    probe();
    edge_();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    fetch(64'h8000_3000, 32'h6666_6666, 1'b0);

    // redirect coinciding with accept, then redirect inside DROP
    exp_req.push_back(64'h8000_3004);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_4000;
    probe();
    edge_();
    imem_req_ready = 1'b0;
    redirect_pc    = 64'h8000_5000;
    probe();
    chk("drop_redir_no_req", 64'(imem_req_valid), 64'd0);
    edge_();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    probe();
    chk("drop_redir_no_req2", 64'(imem_req_valid), 64'd0);
    edge_();
    imem_resp_valid = 1'b0;
    fetch(64'h8000_5000, 32'h7777_7777, 1'b0);

    // access fault delivered, pc still advances
    fetch(64'h8000_5004, 32'h0000_0073, 1'b1);
    fetch(64'h8000_5008, 32'h8888_8888, 1'b0);
    chk("err_cnt", fetch_cnt, 64'd11);

    // pc wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    probe();
    edge_();
    redirect_valid = 1'b0;
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h9999_9999, 1'b0);
    fetch(64'h0000_0000_0000_0000, 32'hAAAA_AAAA, 1'b0);
    chk("wrap_cnt", fetch_cnt, 64'd13);

    // reset in WAIT, redirect during reset ignored
    req(64'h0000_0000_0000_0004);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_1234_0000_0000;
    probe();
    chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    edge_();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    probe();
    chk("midrst_addr", imem_req_addr, 64'h8000_0000);
    chk("midrst_cnt", fetch_cnt, 64'd0);
    chk("midrst_req_valid2", 64'(imem_req_valid), 64'd1);
    edge_();
    fetch(64'h8000_0000, 32'hBBBB_BBBB, 1'b0);
    chk("post_rst_cnt", fetch_cnt, 64'd1);

    chk("req_q_empty", 64'(exp_req.size()), 64'd0);
    chk("out_q_empty", 64'(exp_out.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_fetch_ctrl.md
# ysyx_220066_fetch_ctrl

Fetch sequencer between the PC register and the instruction-memory port of the ysyx_220066 core. It owns the fetch PC and issues one word request at a time over a valid/ready request channel. It captures the response and presents `{pc, inst, err}` to decode through a valid/ready handshake. Redirects from EX or trap logic cancel in-flight work, and stale responses are dropped, so decode only ever sees instructions on the architecturally correct path.

## Interface
- `RESET_PC`, default 64'h8000_0000: fetch PC loaded at reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `redirect_valid`  in  1  redirect request from EX or trap logic.
- `redirect_pc`  in  64  target PC, sampled when `redirect_valid`=1.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  64  request address, equal to the current fetch PC.
- `imem_resp_valid`  in  1  response present; exactly one response per accepted request, arriving no earlier than the cycle after accept.
- `imem_resp_data`  in  32  instruction word.
- `imem_resp_err`  in  1  access fault for this response.
- `out_valid`  out  1  fetched instruction available to decode.
- `out_ready`  in  1  decode consumes the instruction.
- `out_pc`  out  64  PC of the presented instruction.
- `out_inst`  out  32  instruction word.
- `out_err`  out  1  fault flag for the presented instruction.
- `fetch_cnt`  out  64  count of instructions handed to decode.

## Operation
- State register with four states: REQ, WAIT, HOLD, DROP.
- Reset values: state=REQ, pc=`RESET_PC`, out_inst=0, out_err=0, fetch_cnt=0.
  - While `rst`=1, `imem_req_valid`=0 and `out_valid`=0.
- REQ:
  - `imem_req_valid`=1, `imem_req_addr`=pc.
  - Accept (`imem_req_ready`=1) goes to WAIT.
  - Redirect with no accept: pc←redirect_pc, stay in REQ. The address may change while the request is unaccepted, and only on a redirect.
  - Redirect and accept in the same cycle: pc←redirect_pc, go to DROP.
- WAIT:
  - `imem_resp_valid` latches data and err into the out_inst/out_err registers, then goes to HOLD.
  - Redirect without a response: pc←redirect_pc, go to DROP.
  - Redirect with a response in the same cycle: discard the response, pc←redirect_pc, go to REQ.
- DROP:
  - The next `imem_resp_valid` is discarded, then go to REQ.
  - A redirect in DROP updates pc and stays in DROP (the pending response is still discarded).
  - If the response and a redirect coincide: pc←redirect_pc, go to REQ.
- HOLD:
  - `out_valid` = (state==HOLD) & ~`redirect_valid` (combinational kill); `out_pc`=pc.
  - Transfer happens when `out_valid` & `out_ready`: pc←pc+4, fetch_cnt+1, go to REQ.
  - Redirect (priority over `out_ready`): no transfer, no count, pc←redirect_pc, go to REQ.
- Arithmetic:
  - pc+4 is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - fetch_cnt wraps silently.
- An err=1 instruction is delivered like any other. pc still advances by 4; trap logic redirects.
- `redirect_valid` during reset is ignored.

## Timing
- Best case per instruction is 3 cycles: REQ accepted (c0) → response (c1) → HOLD with `out_valid`, transfer (c2) → REQ (c3).
- `out_pc`, `out_inst` and `out_err` are stable while `out_valid`=1 and no transfer has occurred.
- Redirect-to-request latency is 1 cycle: the new pc appears on `imem_req_addr` the cycle after the redirect.
- At most one outstanding memory request at any time.
- Reset asserted mid-operation, in any state, returns to the reset values on the next edge. A response for a request accepted before reset arrives after reset and must not occur; the bench does not generate it.

## Test plan
- **Reset and straight-line fetch.** Release rst, req_ready=1, response 1 cycle after accept, out_ready=1.
  - Addresses 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - out_valid every 3rd cycle; fetch_cnt=3 after 9 cycles.
- **Decode stall.** Hold out_ready=0 for 5 cycles in HOLD.
  - out_valid stays 1 with constant pc/inst; no new imem request; fetch_cnt unchanged.
  - Release: next request address is pc+4.
- **Redirect during WAIT.** Redirect to 0x8000_1000 before the response arrives.
  - State goes to DROP; the late response (inst 0xDEADBEEF) never appears on out.
  - Next request address is 0x8000_1000.
- **Redirect in HOLD with out_ready=1.**
  - out_valid=0 that cycle; fetch_cnt not incremented.
  - Next request address is redirect_pc.
- **Redirect coinciding with response in WAIT, and with accept in REQ.**
  - Coinciding with the response: response discarded, state goes to REQ.
  - Coinciding with the accept: state goes to DROP.
  - In both cases exactly one following request goes to the target.
- **Error and wrap.**
  - Response err=1: out_err=1 delivered and pc advances by 4.
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC: the fetch after it is at address 0.
  - Mid-WAIT rst: req_addr returns to 0x8000_0000 and fetch_cnt=0.
